pc_fetch_sequencer: RTL
=======================

// Module: pc_fetch_sequencer
// PURPOSE
//  Program-counter and instruction-fetch sequencer for the 16-bit CISC core.
//  Holds the PC, issues word fetches to instruction memory, and assembles
//  1- or 2-word instructions. Sits directly upstream of the flip-flop-based
//  instruction register and decode stage, which consume its instr_* outputs.
// PARAMETERS
//  W          16       datapath / address width (bits)
//  RESET_VEC  16'h0000 PC value loaded on reset
//  EXT_BIT    15       bit of first word that flags a 2-word instruction
// PORTS
//  clk          in   1  single clock; all state updates on rising edge
//  rst          in   1  synchronous, active-high reset
//  en           in   1  run enable; sampled in IDLE and FETCH1
//  stall        in   1  downstream backpressure; freezes sequencer
//  mem_ready    in   1  memory returns mem_rdata for current pc this cycle
//  mem_rdata    in   W  instruction word read at pc
//  br_take      in   1  redirect request (one-cycle pulse)
//  br_target    in   W  absolute redirect address
//  pc           out  W  current fetch address (drives memory address)
//  mem_req      out  1  fetch request, combinational from state and stall
//  instr_valid  out  1  one-cycle pulse: instr_w0/w1/ext hold a complete instr
//  instr_w0     out  W  first instruction word
//  instr_w1     out  W  extension word (valid only when instr_ext=1)
//  instr_ext    out  1  1 = two-word instruction
//  pc_wrap      out  1  one-cycle pulse when pc increments 0xFFFF -> 0x0000
// BEHAVIOUR
//  Reset (rst=1 at edge): pc=RESET_VEC, state=IDLE, instr_valid=0,
//   instr_w0=instr_w1=0, instr_ext=0, pc_wrap=0; mem_req=0 while in IDLE.
//  States: IDLE(00), FETCH1(01), FETCH2(10); 11 is illegal -> IDLE.
//  mem_req = (state!=IDLE) & ~stall. A word is accepted ("acc") when
//   mem_req & mem_ready.
//  IDLE: en=1 -> FETCH1. Otherwise hold.
//  FETCH1: acc -> instr_w0<=mem_rdata, pc<=pc+1;
//   if mem_rdata[EXT_BIT]=1 -> FETCH2 (no valid pulse);
//   else instr_ext<=0, instr_valid=1 next cycle, stay FETCH1.
//   No acc and en=0 -> IDLE. en is ignored in FETCH2.
//  FETCH2: acc -> instr_w1<=mem_rdata, pc<=pc+1, instr_ext<=1,
//   instr_valid=1 next cycle, -> FETCH1.
//  Latency: instr_valid rises the cycle after the accepting edge of the
//   last word; back-to-back 1-word instrs give instr_valid every cycle.
//  instr_w0/w1/ext hold their value until the next capture.
//  stall=1: mem_req=0, state and pc held, mem_ready ignored; instr_valid
//   still drops after its one cycle (downstream samples it or stalls first).
//  br_take (priority below rst, above all else): pc<=br_target,
//   state->FETCH1 (from IDLE too), instr_valid=0 next cycle, any
//   first word pending in FETCH2 is discarded. br_take with acc in the
//   same cycle: the accepted word is dropped, no pc increment. br_take
//   with stall=1: redirect still taken.
//  Arithmetic: pc+1 is modulo 2^W; carry out sets pc_wrap for one cycle;
//   a redirect never sets pc_wrap.
//  rst mid-instruction (FETCH2) abandons it; no instr_valid follows.
// STRUCTURE
//  Package pc_fetch_pkg: state encoding constants (S_IDLE, S_FETCH1,
//   S_FETCH2), default W, RESET_VEC, EXT_BIT.
//  Sub-module pc_reg: W-bit register, sync active-high rst to RESET_VEC,
//   ports load/ld_val/inc, outputs q and wrap pulse. The sequencer FSM
//   and the instruction-word capture registers stay in the top module.
// TESTING
//  1 rst, en=1, mem_ready=1, words 0x1234,0x0042 at 0,1 -> instr_valid
//    on cycles 2,3 (after en), w0=0x1234 then 0x0042, ext=0, pc=2.
//  2 word 0x8001 then 0xBEEF -> no pulse after first word; one pulse
//    with w0=0x8001, w1=0xBEEF, ext=1; pc advances by 2.
//  3 stall=1 for 3 cycles mid-FETCH2 -> mem_req=0, pc frozen; on release
//    fetch completes with same w0, single instr_valid pulse.
//  4 br_take=1, br_target=0x0400 during FETCH2 with mem_ready=1 ->
//    pc=0x0400, state FETCH1, no instr_valid, word dropped.
//  5 br_target=0xFFFF, single-word fetch -> pc=0x0000, pc_wrap=1 one cycle.
//  6 rst asserted in FETCH2 -> next cycle pc=RESET_VEC, mem_req=0,
//    instr_valid=0, instr_w0=0.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_pkg
// Description : Shared state encoding and default parameters for the
//               PC / instruction-fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_fetch_pkg;

  localparam int          DEF_W         = 16;
  localparam logic [15:0] DEF_RESET_VEC = 16'h0000;
  localparam int          DEF_EXT_BIT   = 15;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_FETCH1 = 2'b01,
    S_FETCH2 = 2'b10
  } state_t;

endpackage : pc_fetch_pkg
`default_nettype wire

// File: rtl/pc_fetch_sequencer_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg
// Description : Program-counter register with load, modulo increment and a
//               one-cycle wrap pulse on carry out.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_reg #(
  parameter int           W         = 16,
  parameter logic [W-1:0] RESET_VEC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         wrap
);

  logic [W-1:0] r_q;
  logic         r_wrap;
  logic [W:0]   w_sum;

  assign w_sum = {1'b0, r_q} + {{W{1'b0}}, 1'b1};

  // A load has priority over increment and never reports a wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= RESET_VEC;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (load) begin
        r_q <= ld_val;
      end else if (inc) begin
        r_q    <= w_sum[W-1:0];
        r_wrap <= w_sum[W];
      end
    end
  end

  assign q    = r_q;
  assign wrap = r_wrap;

endmodule : pc_reg
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_sequencer
// Description : Holds the PC, issues word fetches and assembles 1- or 2-word
//               instructions for the instruction register / decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer
  import pc_fetch_pkg::*;
#(
  parameter int           W         = DEF_W,
  parameter logic [W-1:0] RESET_VEC = W'(DEF_RESET_VEC),
  parameter int           EXT_BIT   = DEF_EXT_BIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         stall,
  input  logic         mem_ready,
  input  logic [W-1:0] mem_rdata,
  input  logic         br_take,
  input  logic [W-1:0] br_target,
  output logic [W-1:0] pc,
  output logic         mem_req,
  output logic         instr_valid,
  output logic [W-1:0] instr_w0,
  output logic [W-1:0] instr_w1,
  output logic         instr_ext,
  output logic         pc_wrap
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic         w_acc;
  logic         w_take;
  logic         w_cap_w0;
  logic         w_cap_w1;
  logic         w_done;
  logic         r_valid;
  logic [W-1:0] r_w0;
  logic [W-1:0] r_w1;
  logic         r_ext;

  assign mem_req = (r_state != S_IDLE) && !stall;
  assign w_acc   = mem_req && mem_ready;
  // A redirect in the same cycle as an accept drops the accepted word.
  assign w_take  = w_acc && !br_take;

  assign w_cap_w0 = w_take && (r_state == S_FETCH1);
  assign w_cap_w1 = w_take && (r_state == S_FETCH2);
  assign w_done   = w_cap_w1 || (w_cap_w0 && !mem_rdata[EXT_BIT]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (br_take) begin
      w_state_nxt = S_FETCH1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en) w_state_nxt = S_FETCH1;
        end
        S_FETCH1: begin
          if (w_acc) begin
            w_state_nxt = mem_rdata[EXT_BIT] ? S_FETCH2 : S_FETCH1;
          end else if (!stall && !en) begin
            w_state_nxt = S_IDLE;
          end
        end
        S_FETCH2: begin
          if (w_acc) w_state_nxt = S_FETCH1;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_w0    <= '0;
      r_w1    <= '0;
      r_ext   <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_cap_w0) begin
        r_w0 <= mem_rdata;
        if (!mem_rdata[EXT_BIT]) r_ext <= 1'b0;
      end
      if (w_cap_w1) begin
        r_w1  <= mem_rdata;
        r_ext <= 1'b1;
      end
    end
  end

  pc_reg #(
    .W         (W),
    .RESET_VEC (RESET_VEC)
  ) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (br_take),
    .ld_val (br_target),
    .inc    (w_take),
    .q      (pc),
    .wrap   (pc_wrap)
  );

  assign instr_valid = r_valid;
  assign instr_w0    = r_w0;
  assign instr_w1    = r_w1;
  assign instr_ext   = r_ext;

endmodule : pc_fetch_sequencer
`default_nettype wire
